simplez_ctrl: RTL and testbench



---
 rtl/simplez_pkg.sv | 34 +++
 rtl/simplez_step_det.sv | 20 ++
 rtl/simplez_ctrl.sv | 138 +++++++++++++
 tb/tb_simplez_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplez_pkg.sv
// Shared constants for the Simplez control unit: opcodes, ALU op codes,
// FSM state encodings and address-mux selects.
package simplez_pkg;

    localparam logic [2:0] OP_ST   = 3'b000;
    localparam logic [2:0] OP_LD   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_BZ   = 3'b100;
    localparam logic [2:0] OP_CLR  = 3'b101;
    localparam logic [2:0] OP_DEC  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] AC_PASS = 2'b00;
    localparam logic [1:0] AC_ADD  = 2'b01;
    localparam logic [1:0] AC_CLR  = 2'b10;
    localparam logic [1:0] AC_DEC  = 2'b11;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEMRD  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic SEL_PC = 1'b0;
    localparam logic SEL_CD = 1'b1;

    // LD and ADD need a second cycle to consume the synchronous read.
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_LD) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/simplez_step_det.sv
// Rising-edge detector for the synchronised single-step request.
// Ports: clk, rstn (async active-low), step_i (level), rise_o (1-cycle pulse).
module simplez_step_det (
    input  logic clk,
    input  logic rstn,
    input  logic step_i,
    output logic rise_o
);

    logic prev_q;

    // Reset to 1 so a button already held at reset does not fire.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) prev_q <= 1'b1;
        else       prev_q <= step_i;
    end

    assign rise_o = step_i & ~prev_q;

endmodule

// File: rtl/simplez_ctrl.sv
// Simplez control unit: Moore FSM sequencing fetch/decode/execute.
// Ports: clk/rstn, op/z from datapath, run/step controls; register enables,
// ac_op, sel_addr, mem_we, fetch, stop and debug state out.
module simplez_ctrl
    import simplez_pkg::*;
#(
    parameter int OP_W    = 3,
    parameter bit STEP_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [OP_W-1:0] op,
    input  logic            z,
    input  logic            run,
    input  logic            step,
    output logic            clr_pc,
    output logic            inc_pc,
    output logic            ld_pc,
    output logic            ld_ri,
    output logic            ld_ac,
    output logic [1:0]      ac_op,
    output logic            sel_addr,
    output logic            mem_we,
    output logic            fetch,
    output logic            stop,
    output logic [2:0]      state
);

    logic [2:0] state_q, state_d;
    logic [2:0] opc;
    logic       step_rise;
    logic       go;

    logic       dec_clr, dec_inc, dec_ldpc, dec_ldri, dec_ldac;
    logic [1:0] dec_acop;
    logic       dec_sel, dec_we, dec_fetch, dec_stop;

    assign opc = 3'(op);

    simplez_step_det u_step_det (
        .clk    (clk),
        .rstn   (rstn),
        .step_i (step),
        .rise_o (step_rise)
    );

    // Step edges only matter in FETCH; elsewhere they are simply dropped.
    assign go = !STEP_EN || run || step_rise;

    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = go ? S_DECODE : S_FETCH;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (opc == OP_HALT)    state_d = S_HALT;
                else if (is_mem_op(opc)) state_d = S_MEMRD;
                else                   state_d = S_FETCH;
            end
            S_MEMRD:  state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        dec_clr   = 1'b0;
        dec_inc   = 1'b0;
        dec_ldpc  = 1'b0;
        dec_ldri  = 1'b0;
        dec_ldac  = 1'b0;
        dec_acop  = AC_PASS;
        dec_sel   = SEL_PC;
        dec_we    = 1'b0;
        dec_fetch = 1'b0;
        dec_stop  = 1'b0;
        case (state_q)
            S_INIT: dec_clr = 1'b1;
            S_FETCH: begin
                dec_sel   = SEL_PC;
                dec_fetch = 1'b1;
            end
            S_DECODE: begin
                dec_ldri = 1'b1;
                dec_inc  = 1'b1;
            end
            S_EXEC: begin
                case (opc)
                    OP_ST: begin
                        dec_sel = SEL_CD;
                        dec_we  = 1'b1;
                    end
                    OP_LD, OP_ADD: dec_sel = SEL_CD;
                    OP_BR: dec_ldpc = 1'b1;
                    OP_BZ: dec_ldpc = z;
                    OP_CLR: begin
                        dec_acop = AC_CLR;
                        dec_ldac = 1'b1;
                    end
                    OP_DEC: begin
                        dec_acop = AC_DEC;
                        dec_ldac = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEMRD: begin
                // op is still held in RI, so it selects pass vs add here.
                dec_sel  = SEL_CD;
                dec_ldac = 1'b1;
                dec_acop = (opc == OP_ADD) ? AC_ADD : AC_PASS;
            end
            S_HALT: dec_stop = 1'b1;
            default: ;
        endcase
    end

    // Gating with rstn forces every strobe low the moment reset asserts,
    // including the clr_pc that INIT would otherwise decode.
    assign clr_pc   = rstn & dec_clr;
    assign inc_pc   = rstn & dec_inc;
    assign ld_pc    = rstn & dec_ldpc;
    assign ld_ri    = rstn & dec_ldri;
    assign ld_ac    = rstn & dec_ldac;
    assign ac_op    = rstn ? dec_acop : 2'b00;
    assign sel_addr = rstn & dec_sel;
    assign mem_we   = rstn & dec_we;
    assign fetch    = rstn & dec_fetch;
    assign stop     = rstn & dec_stop;
    assign state    = state_q;

endmodule

// File: tb/tb_simplez_ctrl.sv
// Self-checking bench for simplez_ctrl.
// Expected output vectors are queued per cycle and compared at negedge.
module tb_simplez_ctrl;
    import simplez_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] op;
    logic       z, run, step;
    logic       clr_pc, inc_pc, ld_pc, ld_ri, ld_ac;
    logic [1:0] ac_op;
    logic       sel_addr, mem_we, fetch, stop;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    logic [13:0] sb[$];
    logic [13:0] exp_v;

    always #5 clk = ~clk;

    simplez_ctrl #(.OP_W(3), .STEP_EN(1'b1)) dut (
        .clk(clk), .rstn(rstn), .op(op), .z(z), .run(run), .step(step),
        .clr_pc(clr_pc), .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ri(ld_ri),
        .ld_ac(ld_ac), .ac_op(ac_op), .sel_addr(sel_addr),
        .mem_we(mem_we), .fetch(fetch), .stop(stop), .state(state)
    );

    function automatic logic [13:0] outv();
        return {state, clr_pc, inc_pc, ld_pc, ld_ri, ld_ac,
                ac_op, sel_addr, mem_we, fetch, stop};
    endfunction

    function automatic logic [13:0] mk(
        input logic [2:0] st, input logic clr, input logic inc,
        input logic lpc, input logic lri, input logic lac,
        input logic [1:0] aop, input logic sel, input logic we,
        input logic fe, input logic sp);
        return {st, clr, inc, lpc, lri, lac, aop, sel, we, fe, sp};
    endfunction

    function automatic logic [13:0] e_init();
        return mk(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [13:0] e_fetch();
        return mk(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    endfunction
    function automatic logic [13:0] e_decode();
        return mk(3'd2, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [13:0] e_exec(input logic [2:0] o,
                                           input logic zz);
        case (o)
            3'b000:  return mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0);
            3'b001,
            3'b010:  return mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
            3'b011:  return mk(3'd3, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
            3'b100:  return mk(3'd3, 0, 0, zz, 0, 0, 2'b00, 0, 0, 0, 0);
            3'b101:  return mk(3'd3, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0);
            3'b110:  return mk(3'd3, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0);
            default: return mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        endcase
    endfunction
    function automatic logic [13:0] e_memrd(input logic [2:0] o);
        return mk(3'd4, 0, 0, 0, 0, 1, (o == 3'b010) ? 2'b01 : 2'b00,
                  1, 0, 0, 0);
    endfunction
    function automatic logic [13:0] e_halt();
        return mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    endfunction

    task automatic test_reset();
        rstn = 1'b0; run = 1'b0; step = 1'b0; op = 3'b000; z = 1'b0;
        #1;
        sb.push_back(14'd0);
        exp_v = sb.pop_front();
        checks++;
        if (outv() !== exp_v) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", outv(), exp_v);
        end
        repeat (2) begin
            @(negedge clk);
            sb.push_back(14'd0);
            exp_v = sb.pop_front();
            checks++;
            if (outv() !== exp_v) begin
                errors++;
                $display("FAIL reset_hold got=%h exp=%h", outv(), exp_v);
            end
        end
        rstn = 1'b1;
        #1;
        sb.push_back(e_init());
        exp_v = sb.pop_front();
        checks++;
        if (outv() !== exp_v) begin
            errors++;
            $display("FAIL reset_init got=%h exp=%h", outv(), exp_v);
        end
        repeat (2) sb.push_back(e_fetch());
        repeat (2) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (outv() !== exp_v) begin
                errors++;
                $display("FAIL reset_fetch got=%h exp=%h", outv(), exp_v);
            end
        end
    endtask

    task automatic test_ld_add();
        logic [2:0] ops [2];
        ops = '{OP_LD, OP_ADD};
        for (int k = 0; k < 2; k++) begin
            run = 1'b1; op = ops[k];
            sb.push_back(e_decode());
            sb.push_back(e_exec(ops[k], 1'b0));
            sb.push_back(e_memrd(ops[k]));
            sb.push_back(e_fetch());
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                exp_v = sb.pop_front();
                checks++;
                if (outv() !== exp_v) begin
                    errors++;
                    $display("FAIL ld_add op=%0d cyc=%0d got=%h exp=%h",
                             ops[k], i, outv(), exp_v);
                end
            end
            run = 1'b0;
        end
    endtask

    task automatic test_st();
        run = 1'b1; op = OP_ST;
        sb.push_back(e_decode());
        sb.push_back(e_exec(OP_ST, 1'b0));
        sb.push_back(e_fetch());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (outv() !== exp_v) begin
                errors++;
                $display("FAIL st cyc=%0d got=%h exp=%h", i, outv(), exp_v);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_bz();
        logic zs [2];
        zs = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            run = 1'b1; op = OP_BZ; z = zs[k];
            sb.push_back(e_decode());
            sb.push_back(e_exec(OP_BZ, zs[k]));
            sb.push_back(e_fetch());
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                exp_v = sb.pop_front();
                checks++;
                if (outv() !== exp_v) begin
                    errors++;
                    $display("FAIL bz z=%0b cyc=%0d got=%h exp=%h",
                             zs[k], i, outv(), exp_v);
                end
            end
            run = 1'b0;
        end
        z = 1'b0;
    endtask

    task automatic test_alu_br();
        logic [2:0] ops [3];
        ops = '{OP_BR, OP_CLR, OP_DEC};
        for (int k = 0; k < 3; k++) begin
            run = 1'b1; op = ops[k];
            sb.push_back(e_decode());
            sb.push_back(e_exec(ops[k], 1'b0));
            sb.push_back(e_fetch());
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                exp_v = sb.pop_front();
                checks++;
                if (outv() !== exp_v) begin
                    errors++;
                    $display("FAIL alu_br op=%0d cyc=%0d got=%h exp=%h",
                             ops[k], i, outv(), exp_v);
                end
            end
            run = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        run = 1'b1; op = OP_ST;
        sb.push_back(e_decode());
        sb.push_back(e_exec(OP_ST, 1'b0));
        sb.push_back(e_fetch());
        sb.push_back(e_decode());
        sb.push_back(e_exec(OP_ADD, 1'b0));
        sb.push_back(e_memrd(OP_ADD));
        sb.push_back(e_fetch());
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (outv() !== exp_v) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", i, outv(), exp_v);
            end
            if (i == 2) op = OP_ADD;
        end
        run = 1'b0;
    endtask

    task automatic test_step();
        run = 1'b0; step = 1'b0; op = OP_CLR;
        repeat (10) sb.push_back(e_fetch());
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (outv() !== exp_v) begin
                errors++;
                $display("FAIL step_hold cyc=%0d got=%h exp=%h",
                         i, outv(), exp_v);
            end
        end
        step = 1'b1;
        sb.push_back(e_decode());
        sb.push_back(e_exec(OP_CLR, 1'b0));
        repeat (5) sb.push_back(e_fetch());
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (outv() !== exp_v) begin
                errors++;
                $display("FAIL step_one cyc=%0d got=%h exp=%h",
                         i, outv(), exp_v);
            end
            // A fresh edge raised while in EXEC must be discarded.
            if (i == 0) step = 1'b0;
            if (i == 1) step = 1'b1;
        end
        step = 1'b0;
    endtask

    task automatic test_run_drop();
        run = 1'b1; op = OP_LD;
        sb.push_back(e_decode());
        sb.push_back(e_exec(OP_LD, 1'b0));
        sb.push_back(e_memrd(OP_LD));
        repeat (3) sb.push_back(e_fetch());
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (outv() !== exp_v) begin
                errors++;
                $display("FAIL run_drop cyc=%0d got=%h exp=%h",
                         i, outv(), exp_v);
            end
            if (i == 0) run = 1'b0;
        end
    endtask

    task automatic test_halt();
        run = 1'b1; op = OP_HALT;
        sb.push_back(e_decode());
        sb.push_back(e_exec(OP_HALT, 1'b0));
        repeat (7) sb.push_back(e_halt());
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (outv() !== exp_v) begin
                errors++;
                $display("FAIL halt cyc=%0d got=%h exp=%h", i, outv(), exp_v);
            end
            if (i >= 2) begin
                run  = i[0];
                step = ~step;
                op   = 3'(i);
            end
        end
        run = 1'b0; step = 1'b0;
    endtask

    task automatic test_reset_mid_st();
        rstn = 1'b0;
        #1;
        sb.push_back(14'd0);
        exp_v = sb.pop_front();
        checks++;
        if (outv() !== exp_v) begin
            errors++;
            $display("FAIL rst_from_halt got=%h exp=%h", outv(), exp_v);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        sb.push_back(e_init());
        sb.push_back(e_fetch());
        exp_v = sb.pop_front();
        checks++;
        if (outv() !== exp_v) begin
            errors++;
            $display("FAIL rst2_init got=%h exp=%h", outv(), exp_v);
        end
        @(negedge clk);
        exp_v = sb.pop_front();
        checks++;
        if (outv() !== exp_v) begin
            errors++;
            $display("FAIL rst2_fetch got=%h exp=%h", outv(), exp_v);
        end
        run = 1'b1; op = OP_ST;
        sb.push_back(e_decode());
        sb.push_back(e_exec(OP_ST, 1'b0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (outv() !== exp_v) begin
                errors++;
                $display("FAIL mid_st cyc=%0d got=%h exp=%h",
                         i, outv(), exp_v);
            end
        end
        #2;
        rstn = 1'b0;
        #1;
        sb.push_back(14'd0);
        exp_v = sb.pop_front();
        checks++;
        if (outv() !== exp_v) begin
            errors++;
            $display("FAIL mid_st_reset got=%h exp=%h", outv(), exp_v);
        end
        @(negedge clk);
        run = 1'b0;
        rstn = 1'b1;
        #1;
        sb.push_back(e_init());
        sb.push_back(e_fetch());
        exp_v = sb.pop_front();
        checks++;
        if (outv() !== exp_v) begin
            errors++;
            $display("FAIL rst3_init got=%h exp=%h", outv(), exp_v);
        end
        @(negedge clk);
        exp_v = sb.pop_front();
        checks++;
        if (outv() !== exp_v) begin
            errors++;
            $display("FAIL rst3_fetch got=%h exp=%h", outv(), exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_ld_add();
        test_st();
        test_bz();
        test_alu_br();
        test_back_to_back();
        test_step();
        test_run_drop();
        test_halt();
        test_reset_mid_st();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
